morse_decoder: RTL

Serial-to-character Morse decoder: the receive side of the `MORSE_CODE` transmitter. It measures the mark (high) and space (low) durations on a single-bit line and classifies each mark as a dot or a dash. When an inter-character gap is detected, it emits the 5-bit letter index (A=0 … Z=25) with a one-cycle `valid` pulse. It sits behind any `MORSE_CODE` instance or external keyer and feeds character-level logic downstream.

---
 rtl/morse_pkg.sv | 65 ++++++
 rtl/morse_lut.sv | 30 +++
 rtl/morse_decoder.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
// ---------------------------------------------------------------------------
// morse_pkg
//   Definitions shared by the Morse transmitter and receiver: element
//   encoding, default timing values, the decoder FSM state type and the
//   A..Z letter table.
//   Table entries are {len[2:0], pat[3:0]}. The pattern is right-justified:
//   the first element sits in bit len-1 and the last element in bit 0.
//   Unused upper pattern bits are zero.
// ---------------------------------------------------------------------------
package morse_pkg;

    localparam logic DOT  = 1'b0;
    localparam logic DASH = 1'b1;

    localparam int unsigned DOT_MIN_DEF  = 50;
    localparam int unsigned DASH_MIN_DEF = 150;
    localparam int unsigned DASH_MAX_DEF = 300;
    localparam int unsigned CHAR_GAP_DEF = 300;

    localparam int unsigned LETTER_COUNT = 26;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MARK,
        ST_SPACE,
        ST_EMIT,
        ST_ERR,
        ST_RESYNC
    } morse_state_e;

    // Index i of this table is the letter index (A=0 ... Z=25).
    localparam logic [6:0] MORSE_TABLE [LETTER_COUNT] = '{
        {3'd2, 4'b0001},  // A .-
        {3'd4, 4'b1000},  // B -...
        {3'd4, 4'b1010},  // C -.-.
        {3'd3, 4'b0100},  // D -..
        {3'd1, 4'b0000},  // E .
        {3'd4, 4'b0010},  // F ..-.
        {3'd3, 4'b0110},  // G --.
        {3'd4, 4'b0000},  // H ....
        {3'd2, 4'b0000},  // I ..
        {3'd4, 4'b0111},  // J .---
        {3'd3, 4'b0101},  // K -.-
        {3'd4, 4'b0100},  // L .-..
        {3'd2, 4'b0011},  // M --
        {3'd2, 4'b0010},  // N -.
        {3'd3, 4'b0111},  // O ---
        {3'd4, 4'b0110},  // P .--.
        {3'd4, 4'b1101},  // Q --.-
        {3'd3, 4'b0010},  // R .-.
        {3'd3, 4'b0000},  // S ...
        {3'd1, 4'b0001},  // T -
        {3'd3, 4'b0001},  // U ..-
        {3'd4, 4'b0001},  // V ...-
        {3'd3, 4'b0011},  // W .--
        {3'd4, 4'b1001},  // X -..-
        {3'd4, 4'b1011},  // Y -.--
        {3'd4, 4'b1100}   // Z --..
    };

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/morse_lut.sv
// ---------------------------------------------------------------------------
// morse_lut
//   Combinational reverse lookup from an element pattern to a letter index.
//   Ports:
//     len_i  [2:0]  number of elements collected (1..4)
//     pat_i  [3:0]  right-justified element pattern (dot=0, dash=1)
//     hit_o         pattern matches a letter
//     code_o [4:0]  letter index A=0 ... Z=25 (0 when hit_o is low)
// ---------------------------------------------------------------------------
module morse_lut
    import morse_pkg::*;
(
    input  logic [2:0] len_i,
    input  logic [3:0] pat_i,
    output logic       hit_o,
    output logic [4:0] code_o
);

    always_comb begin
        hit_o  = 1'b0;
        code_o = '0;
        for (int unsigned i = 0; i < LETTER_COUNT; i++) begin
            if ({len_i, pat_i} == MORSE_TABLE[i]) begin
                hit_o  = 1'b1;
                code_o = 5'(i);
            end
        end
    end

endmodule

// File: rtl/morse_decoder.sv
// ---------------------------------------------------------------------------
// morse_decoder
//   Receive side of the Morse link. Measures mark/space lengths on a
//   synchronized serial line, builds an element pattern and emits the
//   decoded letter index with a single-cycle valid pulse, or a single-cycle
//   err pulse for malformed marks, overlong characters or unmapped patterns.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     en     decoder enable; low returns to IDLE and drops the partial character
//     in     serial Morse line, asynchronous to clk
//     code   [4:0] letter index, updated together with valid, held otherwise
//     valid  one-cycle pulse, code carries a new letter
//     err    one-cycle pulse, decode error
// ---------------------------------------------------------------------------
module morse_decoder
    import morse_pkg::*;
#(
    parameter int unsigned DOT_MIN  = DOT_MIN_DEF,
    parameter int unsigned DASH_MIN = DASH_MIN_DEF,
    parameter int unsigned DASH_MAX = DASH_MAX_DEF,
    parameter int unsigned CHAR_GAP = CHAR_GAP_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       in,
    output logic [4:0] code,
    output logic       valid,
    output logic       err
);

    // Counter must hold DASH_MAX+1 (overlong detection) and CHAR_GAP.
    localparam int unsigned CNT_W = $clog2(max_u(DASH_MAX, CHAR_GAP) + 2);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] DOT_MIN_C  = CNT_W'(DOT_MIN);
    localparam logic [CNT_W-1:0] DASH_MIN_C = CNT_W'(DASH_MIN);
    localparam logic [CNT_W-1:0] DASH_MAX_C = CNT_W'(DASH_MAX);
    localparam logic [CNT_W-1:0] CHAR_GAP_C = CNT_W'(CHAR_GAP);

    // Synchronizer
    logic s_meta_q;
    logic s_in_q;

    // FSM and datapath
    morse_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       pat_q, pat_d;
    logic [2:0]       len_q, len_d;

    // Registered outputs
    logic [4:0] code_q, code_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;

    // Lookup
    logic       lut_hit;
    logic [4:0] lut_code;

    morse_lut u_lut (
        .len_i  (len_q),
        .pat_i  (pat_q),
        .hit_o  (lut_hit),
        .code_o (lut_code)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_meta_q <= 1'b0;
            s_in_q   <= 1'b0;
        end else begin
            s_meta_q <= in;
            s_in_q   <= s_meta_q;
        end
    end

    // State register (with the counter and pattern datapath)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pat_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        len_d   = len_q;

        if (!en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            pat_d   = '0;
            len_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (s_in_q) begin
                        state_d = ST_MARK;
                        cnt_d   = CNT_ONE;
                    end
                end

                ST_MARK: begin
                    if (s_in_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc > DASH_MAX_C) begin
                            state_d = ST_ERR;
                        end
                    end else if ((cnt_q < DOT_MIN_C) || (len_q == 3'd4)) begin
                        state_d = ST_ERR;
                    end else begin
                        pat_d   = {pat_q[2:0], (cnt_q >= DASH_MIN_C) ? DASH : DOT};
                        len_d   = len_q + 3'd1;
                        state_d = ST_SPACE;
                        cnt_d   = CNT_ONE;
                    end
                end

                ST_SPACE: begin
                    if (s_in_q) begin
                        state_d = ST_MARK;
                        cnt_d   = CNT_ONE;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= CHAR_GAP_C) begin
                            state_d = ST_EMIT;
                        end
                    end
                end

                // A mark that begins exactly as the gap expires is sampled
                // here; entering MARK directly keeps its first cycle counted
                // instead of losing it in a pass through IDLE.
                ST_EMIT: begin
                    pat_d = '0;
                    len_d = '0;
                    if (s_in_q) begin
                        state_d = ST_MARK;
                        cnt_d   = CNT_ONE;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end

                ST_ERR: begin
                    pat_d   = '0;
                    len_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_RESYNC;
                end

                ST_RESYNC: begin
                    if (s_in_q) begin
                        cnt_d = '0;
                    end else if (cnt_inc >= CHAR_GAP_C) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    pat_d   = '0;
                    len_d   = '0;
                end
            endcase
        end
    end

    // Output logic: decided from the current state, registered so the pulse
    // lands the cycle after EMIT/ERR.
    always_comb begin
        valid_d = en && (state_q == ST_EMIT) && lut_hit;
        err_d   = en && ((state_q == ST_ERR) || ((state_q == ST_EMIT) && !lut_hit));
        code_d  = valid_d ? lut_code : code_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            code_q  <= code_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign code  = code_q;
    assign valid = valid_q;
    assign err   = err_q;

endmodule
